full_adder: RTL and testbench
=============================

// Module: full_adder
// PURPOSE
// - Full-adder bit slice: S = A ^ B ^ Cin, Cout = majority(A, B, Cin).
// - Purely combinational; 64 slices chained Cout->Cin form the ALU/PC adders.
// - Clocked side path adds a registered copy of the result with valid
//   tracking, for timing-closed consumers, plus a sticky carry status.
// - Combinational ports are never delayed by the clocked logic.
// PARAMETERS
// - WIDTH  default 1  number of ripple-chained bit slices (WIDTH=1 is the plain cell)
// PORTS
// - clk        in   1      clock; all registers on rising edge
// - reset      in   1      asynchronous, active-high
// - A          in   WIDTH  operand A
// - B          in   WIDTH  operand B
// - Cin        in   1      carry into bit 0
// - S          out  WIDTH  combinational sum
// - Cout       out  1      combinational carry out of bit WIDTH-1
// - in_valid   in   1      capture A/B/Cin result into registers this cycle
// - S_q        out  WIDTH  registered S
// - Cout_q     out  1      registered Cout
// - out_valid  out  1      S_q/Cout_q hold a captured result
// - carry_seen out  1      sticky: set when a captured Cout was 1
// - clr_sticky in   1      synchronous clear of carry_seen
// BEHAVIOUR
// - Internal carry chain: c[0]=Cin; for each bit i: S[i]=A[i]^B[i]^c[i],
//   c[i+1]=(A[i]&B[i])|(c[i]&(A[i]^B[i])); Cout=c[WIDTH].
// - S/Cout: zero latency, no dependence on clk, reset or in_valid.
// - Unsigned modulo 2^WIDTH: {Cout,S} == A+B+Cin for every input.
// - Reset (async, any time): S_q=0, Cout_q=0, out_valid=0, carry_seen=0.
//   S/Cout are unaffected by reset.
// - in_valid=1 at edge: S_q<=S, Cout_q<=Cout, out_valid<=1.
//   Latency is 1 cycle.
// - in_valid=0 at edge: S_q/Cout_q hold; out_valid<=0.
// - carry_seen<=1 when in_valid & Cout.
// - clr_sticky & in_valid & Cout in the same cycle: the set wins,
//   carry_seen=1.
// - clr_sticky alone: carry_seen<=0.
// - Reset mid-operation: captured data is discarded and out_valid drops
//   immediately.
// - X on inputs must not corrupt registers while in_valid=0.
// CONFIGURATION
// - Macro FULL_ADDER_STATS_EN:
//   - Defined: adds output carry_cnt[15:0], reset 0.
//   - carry_cnt increments on each in_valid & Cout and saturates at 16'hFFFF.
//   - clr_sticky also clears carry_cnt, with the same set-wins priority.
//   - Undefined: the port and counter do not exist; all else is identical.
// STRUCTURE
// - full_adder_pkg: typedef logic [WIDTH-1:0] word_t pattern, CNT_W=16
//   and CNT_MAX constants.
// - Sub-module fa_cell: 1-bit combinational full adder (A, B, Cin -> S, Cout).
//   It is generated WIDTH times.
// - full_adder keeps the chain generate loop, the capture registers,
//   the sticky flag and the optional counter.
// TESTING
// - Exhaustive WIDTH=1 truth table, all 8 A/B/Cin combos:
//   - 1,1,0 -> S=0, Cout=1; 1,1,1 -> S=1, Cout=1; 0,0,0 -> S=0, Cout=0.
// - 64-slice chain, Cin=0:
//   - 1+1 -> 2.
//   - 0+0 -> 0.
//   - FFFF_FFFF_FFFF_FFFF + FFFF_FFFF_FFFF_FFFF -> FFFF_FFFF_FFFF_FFFE,
//     Cout=1.
//   - 7FFF_FFFF_FFFF_FFFF + 7FFF_FFFF_FFFF_FFFF -> FFFF_FFFF_FFFF_FFFE.
// - 100 random 64-bit pairs:
//   - S must equal A+B on each pair, with 100 ns settle per vector.
// - Registered path, WIDTH=8:
//   - A=8'hFF, B=8'h01, in_valid=1 -> next cycle S_q=8'h00, Cout_q=1,
//     out_valid=1, carry_seen=1.
//   - in_valid=0 -> out_valid=0, S_q holds.
// - Async reset asserted between edges -> S_q/Cout_q/out_valid/carry_seen
//   go to 0 before the next edge; S still tracks the inputs.
// - FULL_ADDER_STATS_EN:
//   - 3 carry captures -> carry_cnt=3.
//   - clr_sticky together with a carry capture -> carry_cnt stays
//     nonzero and carry_seen=1.

Source files
------------

// File: rtl/full_adder_pkg.sv
// Shared types and constants for the full_adder bit-slice adder.
// The optional carry statistics counter is enabled by FULL_ADDER_STATS_EN.
package full_adder_pkg;

  // Carry statistics counter width and its saturation ceiling.
  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef logic [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/fa_cell.sv
// One-bit combinational full adder: the slice repeated along the carry chain.
module fa_cell
  import full_adder_pkg::*;
(
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic S,
  output logic Cout
);

  logic half;

  // Propagate term is shared by the sum and the carry.
  always_comb begin
    half = A ^ B;
    S    = half ^ Cin;
    Cout = (A & B) | (Cin & half);
  end

endmodule

// File: rtl/full_adder.sv
// Ripple-chained full adder of WIDTH slices with a registered side copy of
// the result, valid tracking and a sticky carry flag. The combinational
// S/Cout outputs never pass through the clocked logic.
// Optional feature macro: FULL_ADDER_STATS_EN adds a saturating carry_cnt.
module full_adder
  import full_adder_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  input  logic             in_valid,
  output logic [WIDTH-1:0] S_q,
  output logic             Cout_q,
  output logic             out_valid,
  output logic             carry_seen,
  input  logic             clr_sticky
`ifdef FULL_ADDER_STATS_EN
  ,
  output logic [CNT_W-1:0] carry_cnt
`endif
);

  typedef logic [WIDTH-1:0] word_t;

  logic [WIDTH:0] c;
  word_t          s_p0;
  logic           cout_p0;
  logic           vld_p0;
  logic           seen_p0;

  assign c[0] = Cin;

  genvar i;
  generate
    for (i = 0; i < WIDTH; i++) begin : g_slice
      fa_cell u_cell (
        .A    (A[i]),
        .B    (B[i]),
        .Cin  (c[i]),
        .S    (S[i]),
        .Cout (c[i+1])
      );
    end
  endgenerate

  assign Cout = c[WIDTH];

  // ---- stage p0: capture of the combinational result ----

  // Result registers load only on in_valid, so X on A/B while idle is ignored.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s_p0    <= '0;
      cout_p0 <= 1'b0;
    end else if (in_valid) begin
      s_p0    <= S;
      cout_p0 <= Cout;
    end
  end

  // Valid follows in_valid one cycle later and drops whenever no capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) vld_p0 <= 1'b0;
    else       vld_p0 <= in_valid;
  end

  // Sticky carry: a carry capture outranks a clear in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                 seen_p0 <= 1'b0;
    else if (in_valid && Cout) seen_p0 <= 1'b1;
    else if (clr_sticky)       seen_p0 <= 1'b0;
  end

  assign S_q        = s_p0;
  assign Cout_q     = cout_p0;
  assign out_valid  = vld_p0;
  assign carry_seen = seen_p0;

`ifdef FULL_ADDER_STATS_EN
  cnt_t cnt_p0;

  function automatic cnt_t sat_inc(input cnt_t v);
    return (v == CNT_MAX) ? v : v + cnt_t'(1);
  endfunction

  // Saturating carry counter with the same set-wins priority as the flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                 cnt_p0 <= '0;
    else if (in_valid && Cout) cnt_p0 <= sat_inc(cnt_p0);
    else if (clr_sticky)       cnt_p0 <= '0;
  end

  assign carry_cnt = cnt_p0;
`endif

endmodule

// File: tb/tb_full_adder.sv
// Directed self-checking bench for full_adder at WIDTH=1, 64 and 8.
module tb_full_adder;
  import full_adder_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // WIDTH=1 instance
  logic a1, b1, cin1, s1, co1, v1, sq1, coq1, ov1, cs1, clr1;
  // WIDTH=64 instance
  logic [63:0] a64, b64, s64, sq64;
  logic cin64, co64, v64, coq64, ov64, cs64, clr64;
  // WIDTH=8 instance
  logic [7:0] a8, b8, s8, sq8;
  logic cin8, co8, v8, coq8, ov8, cs8, clr8;
`ifdef FULL_ADDER_STATS_EN
  logic [CNT_W-1:0] cnt1, cnt64, cnt8;
`endif

  full_adder #(.WIDTH(1)) u_w1 (
    .clk(clk), .reset(rst), .A(a1), .B(b1), .Cin(cin1), .S(s1), .Cout(co1),
    .in_valid(v1), .S_q(sq1), .Cout_q(coq1), .out_valid(ov1),
    .carry_seen(cs1), .clr_sticky(clr1)
`ifdef FULL_ADDER_STATS_EN
    , .carry_cnt(cnt1)
`endif
  );

  full_adder #(.WIDTH(64)) u_w64 (
    .clk(clk), .reset(rst), .A(a64), .B(b64), .Cin(cin64), .S(s64), .Cout(co64),
    .in_valid(v64), .S_q(sq64), .Cout_q(coq64), .out_valid(ov64),
    .carry_seen(cs64), .clr_sticky(clr64)
`ifdef FULL_ADDER_STATS_EN
    , .carry_cnt(cnt64)
`endif
  );

  full_adder #(.WIDTH(8)) u_w8 (
    .clk(clk), .reset(rst), .A(a8), .B(b8), .Cin(cin8), .S(s8), .Cout(co8),
    .in_valid(v8), .S_q(sq8), .Cout_q(coq8), .out_valid(ov8),
    .carry_seen(cs8), .clr_sticky(clr8)
`ifdef FULL_ADDER_STATS_EN
    , .carry_cnt(cnt8)
`endif
  );

  task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0]  tt_s;
    logic [7:0]  tt_co;
    logic [2:0]  abc;
    logic [63:0] ra, rb;
    logic [64:0] rsum;

    a1 = 0; b1 = 0; cin1 = 0; v1 = 0; clr1 = 0;
    a64 = '0; b64 = '0; cin64 = 0; v64 = 0; clr64 = 0;
    a8 = '0; b8 = '0; cin8 = 0; v8 = 0; clr8 = 0;

    // Reset state
    #2;
    check("rst_sq", sq8, 8'h00);
    check("rst_coq", coq8, 1'b0);
    check("rst_ov", ov8, 1'b0);
    check("rst_cs", cs8, 1'b0);
    #1 rst = 1'b0;

    // WIDTH=1 truth table; index bits are {A,B,Cin}
    tt_s  = 8'b1001_0110;
    tt_co = 8'b1110_1000;
    for (int i = 0; i < 8; i++) begin
      abc = 3'(i);
      a1 = abc[2]; b1 = abc[1]; cin1 = abc[0];
      #5;
      check($sformatf("tt_s_%0d", i), s1, tt_s[i]);
      check($sformatf("tt_co_%0d", i), co1, tt_co[i]);
    end

    // 64-slice directed sums, Cin=0
    a64 = 64'd1; b64 = 64'd1; #10;
    check("c64_1p1", {co64, s64}, 65'd2);
    a64 = 64'd0; b64 = 64'd0; #10;
    check("c64_0p0", {co64, s64}, 65'd0);
    a64 = 64'hFFFF_FFFF_FFFF_FFFF; b64 = 64'hFFFF_FFFF_FFFF_FFFF; #10;
    check("c64_ff_s", s64, 64'hFFFF_FFFF_FFFF_FFFE);
    check("c64_ff_co", co64, 1'b1);
    a64 = 64'h7FFF_FFFF_FFFF_FFFF; b64 = 64'h7FFF_FFFF_FFFF_FFFF; #10;
    check("c64_7f_s", s64, 64'hFFFF_FFFF_FFFF_FFFE);
    check("c64_7f_co", co64, 1'b0);
    cin64 = 1'b1; a64 = 64'hFFFF_FFFF_FFFF_FFFF; b64 = 64'd0; #10;
    check("c64_cin_ripple", {co64, s64}, {1'b1, 64'd0});
    cin64 = 1'b0;

    // Random 64-bit pairs
    for (int i = 0; i < 100; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      a64 = ra; b64 = rb;
      #100;
      rsum = {1'b0, ra} + {1'b0, rb};
      check($sformatf("rnd_%0d", i), {co64, s64}, rsum);
    end

    // Registered path, WIDTH=8
    tick();
    a8 = 8'hFF; b8 = 8'h01; v8 = 1;
    tick();
    check("reg_sq", sq8, 8'h00);
    check("reg_coq", coq8, 1'b1);
    check("reg_ov", ov8, 1'b1);
    check("reg_cs", cs8, 1'b1);
    v8 = 0; a8 = 'x; b8 = 'x;
    tick();
    check("idle_ov", ov8, 1'b0);
    check("idle_sq_hold", sq8, 8'h00);
    check("idle_coq_hold", coq8, 1'b1);
    check("idle_cs_hold", cs8, 1'b1);
    a8 = 8'h12; b8 = 8'h34; clr8 = 1;
    tick();
    check("clr_cs", cs8, 1'b0);
    clr8 = 0; v8 = 1;
    tick();
    check("cap2_sq", sq8, 8'h46);
    check("cap2_coq", coq8, 1'b0);
    check("cap2_cs", cs8, 1'b0);
    a8 = 8'hF0; b8 = 8'h20;
    tick();
    check("cap3_sq", sq8, 8'h10);
    check("cap3_cs", cs8, 1'b1);
    v8 = 0;

    // Async reset between edges
    #3 rst = 1'b1;
    a8 = 8'h05; b8 = 8'h03;
    #2;
    check("arst_sq", sq8, 8'h00);
    check("arst_coq", coq8, 1'b0);
    check("arst_ov", ov8, 1'b0);
    check("arst_cs", cs8, 1'b0);
    check("arst_s_live", {co8, s8}, 9'h008);
    #1 rst = 1'b0;

`ifdef FULL_ADDER_STATS_EN
    tick();
    check("cnt_rst", cnt8, 16'd0);
    a8 = 8'h80; b8 = 8'h80; v8 = 1;
    tick(); tick(); tick();
    v8 = 0;
    check("cnt_3", cnt8, 16'd3);
    v8 = 1; clr8 = 1;
    tick();
    check("cnt_setwins", cnt8, 16'd4);
    check("cs_setwins", cs8, 1'b1);
    v8 = 0;
    tick();
    check("cnt_clr", cnt8, 16'd0);
    check("cs_clr", cs8, 1'b0);
    clr8 = 0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
